// File: rtl/rx_frame_control_module.sv
// UART receive controller: 2-flop synchroniser, false-start rejection, configurable
// data/parity/stop framing, and a valid/ready output with overrun reporting.
module rx_frame_control_module #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  input  logic                 rx_en_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_sig,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // ones_odd is the XOR of every data bit and the parity bit
  function automatic logic parity_bad(input logic ones_odd);
    case (PARITY_MODE)
      1:       return ~ones_odd;
      2:       return ones_odd;
      default: return 1'b0;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s, rx_s_dly_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   facc_q, facc_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q;
  logic                   done_s, stop_bad_s;

  assign rx_s = sync_q[1];

  // Next-state logic for the frame FSM and the output register
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    facc_d     = facc_q;
    data_d     = data_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    ovr_d      = 1'b0;
    done_s     = 1'b0;
    stop_bad_s = facc_q | ~rx_s;
    valid_d    = (valid_q && rx_ready) ? 1'b0 : valid_q;

    if (state_q != IDLE && !rx_en_sig) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_en_sig && rx_s_dly_q && !rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            bit_d   = 4'd0;
            par_d   = 1'b0;
            facc_d  = 1'b0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            par_d   = par_q ^ rx_s;
            if (bit_q == DATA_LAST) begin
              bit_d   = 4'd0;
              state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            par_d   = par_q ^ rx_s;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d  = '0;
            facc_d = stop_bad_s;
            if (bit_q == STOP_LAST) begin
              done_s  = 1'b1;
              state_d = IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A finished frame loads only if the slot is free or being emptied this cycle
    if (done_s) begin
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        ferr_d  = stop_bad_s;
        perr_d  = parity_bad(par_q);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      ovr_d = 1'b0;
    end
  end

  // State, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      rx_s_dly_q <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      facc_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], rx_pin_in};
      rx_s_dly_q <= rx_s;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      facc_q     <= facc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign parity_err  = perr_q;
  assign overrun_sig = ovr_q;
  assign rx_busy     = busy_q;

endmodule

// File: tb/tb_rx_frame_control_module.sv
// Scoreboard bench: four receiver instances with different framing, each fed by its own line.
module tb_rx_frame_control_module;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] pin_s, en_s, rdy_s;
  logic [3:0] valid_s, ferr_s, perr_s, ovr_s, busy_s;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic [8:0] d3;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       ferr;
    logic       perr;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         rise_cyc[4];
  int         ovr_cnt[4];
  logic [3:0] vprev = 4'b0000;

  rx_frame_control_module #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx_pin_in(pin_s[0]), .rx_en_sig(en_s[0]), .rx_data(d0),
    .rx_valid(valid_s[0]), .rx_ready(rdy_s[0]), .frame_err(ferr_s[0]), .parity_err(perr_s[0]),
    .overrun_sig(ovr_s[0]), .rx_busy(busy_s[0]));
  rx_frame_control_module #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx_pin_in(pin_s[1]), .rx_en_sig(en_s[1]), .rx_data(d1),
    .rx_valid(valid_s[1]), .rx_ready(rdy_s[1]), .frame_err(ferr_s[1]), .parity_err(perr_s[1]),
    .overrun_sig(ovr_s[1]), .rx_busy(busy_s[1]));
  rx_frame_control_module #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx_pin_in(pin_s[2]), .rx_en_sig(en_s[2]), .rx_data(d2),
    .rx_valid(valid_s[2]), .rx_ready(rdy_s[2]), .frame_err(ferr_s[2]), .parity_err(perr_s[2]),
    .overrun_sig(ovr_s[2]), .rx_busy(busy_s[2]));
  rx_frame_control_module #(.CLKS_PER_BIT(17), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .rx_pin_in(pin_s[3]), .rx_en_sig(en_s[3]), .rx_data(d3),
    .rx_valid(valid_s[3]), .rx_ready(rdy_s[3]), .frame_err(ferr_s[3]), .parity_err(perr_s[3]),
    .overrun_sig(ovr_s[3]), .rx_busy(busy_s[3]));

  function automatic int cpb_of(input int i);
    case (i)
      2:       return 4;
      3:       return 17;
      default: return 16;
    endcase
  endfunction

  function automatic int db_of(input int i);
    case (i)
      2:       return 5;
      3:       return 9;
      default: return 8;
    endcase
  endfunction

  function automatic int pm_of(input int i);
    case (i)
      1:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_of(input int i);
    return (i >= 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] get_data(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {4'b0000, d2};
      default: return d3;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after a negedge; stops[k] is the level driven for stop bit k.
  task automatic send_frame(input int i, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops, input logic push);
    int   cpb, db, pm, sb, ones, nbits;
    exp_t e;
    cpb = cpb_of(i); db = db_of(i); pm = pm_of(i); sb = sb_of(i);
    ones = 0;
    for (int b = 0; b < db; b++) if (d[b]) ones++;
    if (pm != 0 && pbit) ones++;
    nbits  = db + ((pm != 0) ? 1 : 0) + sb;
    e.inst = i;
    e.data = d;
    e.perr = (pm == 1) ? (ones % 2 == 0) : (pm == 2) ? (ones % 2 == 1) : 1'b0;
    e.ferr = (sb == 2) ? !(stops[0] && stops[1]) : !stops[0];
    e.cyc  = (cyc + 1) + 2 + cpb / 2 + cpb * nbits;
    if (push) sb_q.push_back(e);
    pin_s[i] = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int b = 0; b < db; b++) begin
      pin_s[i] = d[b];
      repeat (cpb) @(negedge clk);
    end
    if (pm != 0) begin
      pin_s[i] = pbit;
      repeat (cpb) @(negedge clk);
    end
    for (int s = 0; s < sb; s++) begin
      pin_s[i] = stops[s];
      repeat (cpb) @(negedge clk);
    end
    pin_s[i] = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: a handshake (valid && ready before the edge) pops and checks one expected word
  initial begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      rise_cyc[i] = 0;
      ovr_cnt[i]  = 0;
    end
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (valid_s[i] && !vprev[i]) rise_cyc[i] = cyc;
        if (ovr_s[i]) ovr_cnt[i]++;
        if (valid_s[i] && rdy_s[i] && !rst) begin
          if (sb_q.size() == 0) begin
            check_eq($sformatf("spurious_word%0d", i), 32'(get_data(i)), 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            check_eq("word_inst", 32'(i), 32'(e.inst));
            check_eq($sformatf("rx_data%0d", i), 32'(get_data(i)), 32'(e.data));
            check_eq($sformatf("frame_err%0d", i), 32'(ferr_s[i]), 32'(e.ferr));
            check_eq($sformatf("parity_err%0d", i), 32'(perr_s[i]), 32'(e.perr));
            check_eq($sformatf("latency%0d", i), 32'(rise_cyc[i]), 32'(e.cyc));
          end
        end
      end
      vprev = valid_s;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst = 1'b1; pin_s = 4'hF; en_s = 4'hF; rdy_s = 4'hF;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(valid_s), 32'h0);
    check_eq("rst_busy", 32'(busy_s), 32'h0);
    check_eq("rst_ferr", 32'(ferr_s), 32'h0);
    check_eq("rst_perr", 32'(perr_s), 32'h0);
    check_eq("rst_ovr", 32'(ovr_s), 32'h0);
    check_eq("rst_data0", 32'(d0), 32'h0);
    rst = 1'b0;
    idle(5);

    // 8N1 single word
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
    idle(20);

    // 8E1: correct then wrong parity
    send_frame(1, 9'h0A5, 1'b0, 2'b11, 1'b1);
    idle(20);
    send_frame(1, 9'h0A5, 1'b1, 2'b11, 1'b1);
    idle(20);

    // Stop bit low
    send_frame(0, 9'h03C, 1'b0, 2'b10, 1'b1);
    idle(40);

    // 5-cycle low glitch is a false start
    pin_s[0] = 1'b0;
    t0 = cyc + 1;
    idle(5);
    pin_s[0] = 1'b1;
    while (cyc < t0 + 3) @(negedge clk);
    check_eq("glitch_busy_high", 32'(busy_s[0]), 32'h1);
    while (cyc < t0 + 10) @(negedge clk);
    check_eq("glitch_busy_low", 32'(busy_s[0]), 32'h0);
    idle(40);

    // Overrun: consumer stalled across two frames
    rdy_s[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1);
    send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
    idle(10);
    check_eq("ovr_valid_held", 32'(valid_s[0]), 32'h1);
    check_eq("ovr_data_held", 32'(d0), 32'h11);
    check_eq("ovr_pulse_count", 32'(ovr_cnt[0]), 32'h1);
    rdy_s[0] = 1'b1;
    @(negedge clk);
    check_eq("ovr_valid_drop", 32'(valid_s[0]), 32'h0);
    idle(20);

    // Abort mid-DATA by dropping enable
    pin_s[0] = 1'b0;
    idle(16);
    pin_s[0] = 1'b1; idle(16);
    pin_s[0] = 1'b0; idle(16);
    check_eq("abort_busy_before", 32'(busy_s[0]), 32'h1);
    en_s[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_busy_after", 32'(busy_s[0]), 32'h0);
    idle(30);
    pin_s[0] = 1'b1;
    idle(200);
    en_s[0] = 1'b1;
    idle(20);

    // Reset mid-frame while an unread word is held
    rdy_s[0] = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b0);
    idle(5);
    check_eq("pre_rst_valid", 32'(valid_s[0]), 32'h1);
    check_eq("pre_rst_data", 32'(d0), 32'h5A);
    pin_s[0] = 1'b0;
    idle(40);
    pin_s[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(valid_s[0]), 32'h0);
    check_eq("mid_rst_data", 32'(d0), 32'h0);
    check_eq("mid_rst_busy", 32'(busy_s[0]), 32'h0);
    check_eq("mid_rst_flags", 32'({ferr_s[0], perr_s[0], ovr_s[0]}), 32'h0);
    rdy_s[0] = 1'b1;
    idle(30);

    // Back-to-back frames, always-ready consumer
    send_frame(0, 9'h001, 1'b0, 2'b11, 1'b1);
    send_frame(0, 9'h0FE, 1'b0, 2'b11, 1'b1);
    send_frame(0, 9'h080, 1'b0, 2'b11, 1'b1);
    idle(30);

    // Parameter sweep: 5 data bits / 2 stops / 4 clocks, and 9 data bits odd parity / 17 clocks
    send_frame(2, 9'h015, 1'b0, 2'b11, 1'b1);
    send_frame(2, 9'h00A, 1'b0, 2'b11, 1'b1);
    send_frame(2, 9'h01F, 1'b0, 2'b01, 1'b1);
    idle(20);
    send_frame(3, 9'h1A5, 1'b0, 2'b11, 1'b1);
    send_frame(3, 9'h100, 1'b0, 2'b11, 1'b1);
    send_frame(3, 9'h0FF, 1'b0, 2'b11, 1'b1);
    idle(60);

    check_eq("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    check_eq("ovr_total0", 32'(ovr_cnt[0]), 32'h1);
    check_eq("ovr_total_others", 32'(ovr_cnt[1] + ovr_cnt[2] + ovr_cnt[3]), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
